phase_shift_divider: RTL and testbench

- Programmable clock divider for the PLL's DPKD path, with digital phase advance/retard.
- Each output period is nominally div_i reference cycles.
- Accepted shift requests shorten (advance) or lengthen (retard) one period by STEP cycles.
- Requests are queued in a saturating signed accumulator and applied at most one per period.

---
 rtl/phase_shift_divider.sv | 238 +++++++++++++++++++++++
 tb/tb_phase_shift_divider.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_shift_divider.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// phase_shift_divider
//
// Programmable clock divider for the PLL DPKD path with digital phase
// advance/retard. Each output period is nominally div_i reference cycles.
// Shift requests are queued in a saturating signed accumulator. At most one
// queued request is applied per period. An advance shortens that period by
// STEP cycles and a retard lengthens it by STEP cycles.
//
// Parameters
//   WIDTH   width of divisor, period counter and period length
//   STEP    cycles removed/added per applied shift (1..2^(WIDTH-2))
//   PEND_W  width of the signed pending-shift accumulator
//
// Ports
//   clk_i            reference clock
//   reset_i          asynchronous active-low reset
//   div_i            nominal divisor, sampled in the period-start cycle (<2 -> 2)
//   positiveShift_i  advance request, one per high cycle
//   negativeShift_i  retard request, one per high cycle (both high = cancel)
//   ovf_clr_i        synchronous clear of ovf_o (a same-cycle set wins)
//   out_o            divided clock, high while cnt < floor(L/2)
//   period_o         strobe on the first cycle (cnt == 0) of every period
//   pending_o        signed pending-shift accumulator
//   ovf_o            sticky accumulator saturation flag
//
// Optional feature (macro PHASE_SHIFT_DIVIDER_STATS_EN)
//   adv_cnt_o / ret_cnt_o  wrapping 16-bit counts of applied advances/retards,
//                          cleared by reset and by ovf_clr_i
// ---------------------------------------------------------------------------
module phase_shift_divider #(
  parameter int WIDTH  = 8,
  parameter int STEP   = 1,
  parameter int PEND_W = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [WIDTH-1:0]         div_i,
  input  logic                     positiveShift_i,
  input  logic                     negativeShift_i,
  input  logic                     ovf_clr_i,
  output logic                     out_o,
  output logic                     period_o,
  output logic signed [PEND_W-1:0] pending_o,
  output logic                     ovf_o
`ifdef PHASE_SHIFT_DIVIDER_STATS_EN
  ,
  output logic [15:0]              adv_cnt_o,
  output logic [15:0]              ret_cnt_o
`endif
);

  // Length arithmetic uses one extra bit so that N+STEP cannot wrap before
  // it is clamped. Accumulator arithmetic uses two extra bits so that
  // pending + delta - applied is always representable before saturation.
  localparam int EW = WIDTH + 1;
  localparam int AW = PEND_W + 2;

  localparam logic [EW-1:0]        STEP_X = EW'(STEP);
  localparam logic [EW-1:0]        MIN_LX = EW'(2);
  localparam logic [EW-1:0]        MAX_LX = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0]     MIN_L  = WIDTH'(2);
  localparam logic signed [AW-1:0] P_MAX  = AW'((1 << (PEND_W - 1)) - 1);
  localparam logic signed [AW-1:0] P_MIN  = -P_MAX;

  // Advanced period length: max(N - STEP, 2)
  function automatic logic [WIDTH-1:0] len_advance(input logic [WIDTH-1:0] n);
    logic [EW-1:0] nx;
    nx = {1'b0, n};
    if (nx < STEP_X + MIN_LX) begin
      return MIN_L;
    end
    return WIDTH'(nx - STEP_X);
  endfunction

  // Retarded period length: min(N + STEP, 2^WIDTH - 1)
  function automatic logic [WIDTH-1:0] len_retard(input logic [WIDTH-1:0] n);
    logic [EW-1:0] sx;
    sx = {1'b0, n} + STEP_X;
    if (sx > MAX_LX) begin
      return {WIDTH{1'b1}};
    end
    return sx[WIDTH-1:0];
  endfunction

  // True when the raw accumulator sum lies outside the symmetric range
  function automatic logic sat_hit(input logic signed [AW-1:0] v);
    return (v > P_MAX) || (v < P_MIN);
  endfunction

  // Clamp the raw accumulator sum to +/-(2^(PEND_W-1)-1)
  function automatic logic signed [PEND_W-1:0] sat_pending(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] c;
    if (v > P_MAX) begin
      c = P_MAX;
    end else if (v < P_MIN) begin
      c = P_MIN;
    end else begin
      c = v;
    end
    return c[PEND_W-1:0];
  endfunction

  // Registered state
  logic                     run_p0;   // low until the first edge after reset
  logic [WIDTH-1:0]         cnt_p0;
  logic [WIDTH-1:0]         len_p0;
  logic signed [PEND_W-1:0] pend_p0;

  // Next-state terms
  logic [WIDTH-1:0]         n_sel;
  logic [WIDTH-1:0]         len_new;
  logic [WIDTH-1:0]         eff_len;
  logic [WIDTH-1:0]         cnt_nxt;
  logic                     is_start;
  logic                     pend_pos;
  logic                     pend_neg;
  logic                     adv_take;
  logic                     ret_take;
  logic                     out_nxt;
  logic                     per_nxt;
  logic                     sat;
  logic signed [AW-1:0]     delta;
  logic signed [AW-1:0]     applied;
  logic signed [AW-1:0]     pend_sum;
  logic signed [PEND_W-1:0] pend_nxt;

  // The length of a period is decided in its own start cycle (cnt == 0).
  // out_o is 1 in that cycle for every legal L (>= 2), so the new length
  // only needs to be registered from cnt == 1 onward. The decision reads the
  // registered accumulator, so a request made in the start cycle itself
  // cannot affect the current period.
  always_comb begin
    n_sel    = (div_i < MIN_L) ? MIN_L : div_i;
    is_start = run_p0 && (cnt_p0 == '0);
    pend_pos = !pend_p0[PEND_W-1] && (pend_p0 != '0);
    pend_neg = pend_p0[PEND_W-1];

    len_new  = n_sel;
    if (pend_pos) begin
      len_new = len_advance(n_sel);
    end else if (pend_neg) begin
      len_new = len_retard(n_sel);
    end

    adv_take = is_start && pend_pos;
    ret_take = is_start && pend_neg;
    eff_len  = is_start ? len_new : len_p0;

    delta = '0;
    if (positiveShift_i && !negativeShift_i) begin
      delta = AW'(1);
    end else if (negativeShift_i && !positiveShift_i) begin
      delta = AW'(-1);
    end

    applied = '0;
    if (adv_take) begin
      applied = AW'(1);
    end else if (ret_take) begin
      applied = AW'(-1);
    end

    pend_sum = AW'(pend_p0) + delta - applied;
    sat      = sat_hit(pend_sum);
    pend_nxt = sat_pending(pend_sum);

    if (!run_p0) begin
      cnt_nxt = '0;
    end else if (cnt_p0 == eff_len - WIDTH'(1)) begin
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt_p0 + WIDTH'(1);
    end

    // At a wrap eff_len is still the old length, but 0 < floor(L/2) holds
    // for any L >= 2, so the start cycle is always high.
    out_nxt = cnt_nxt < (eff_len >> 1);
    per_nxt = (cnt_nxt == '0);
  end

  // ---- stage p0: counter, period length, accumulator and outputs ----
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      run_p0   <= 1'b0;
      cnt_p0   <= '0;
      len_p0   <= MIN_L;
      pend_p0  <= '0;
      out_o    <= 1'b0;
      period_o <= 1'b0;
      ovf_o    <= 1'b0;
    end else begin
      run_p0   <= 1'b1;
      cnt_p0   <= cnt_nxt;
      if (is_start) begin
        len_p0 <= len_new;
      end
      pend_p0  <= pend_nxt;
      out_o    <= out_nxt;
      period_o <= per_nxt;
      if (sat) begin
        ovf_o <= 1'b1;
      end else if (ovf_clr_i) begin
        ovf_o <= 1'b0;
      end
    end
  end

  assign pending_o = pend_p0;

`ifdef PHASE_SHIFT_DIVIDER_STATS_EN
  logic [15:0] adv_cnt_p0;
  logic [15:0] ret_cnt_p0;

  // ---- stage p0: applied-shift statistics ----
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      adv_cnt_p0 <= '0;
      ret_cnt_p0 <= '0;
    end else if (ovf_clr_i) begin
      adv_cnt_p0 <= '0;
      ret_cnt_p0 <= '0;
    end else begin
      if (adv_take) begin
        adv_cnt_p0 <= adv_cnt_p0 + 16'd1;
      end
      if (ret_take) begin
        ret_cnt_p0 <= ret_cnt_p0 + 16'd1;
      end
    end
  end

  assign adv_cnt_o = adv_cnt_p0;
  assign ret_cnt_o = ret_cnt_p0;
`endif

endmodule

// File: tb/tb_phase_shift_divider.sv
`timescale 1ns/1ps
// Scoreboard bench for phase_shift_divider. A period-level reference model
// builds the expected waveform of each whole period as a queue when that
// period starts; per-cycle expectations are pushed by the stimulus process
// and popped by an independent monitor on the falling clock edge.
module tb_phase_shift_divider;

  localparam int WIDTH  = 8;
  localparam int STEP   = 1;
  localparam int PEND_W = 4;
  localparam int PMAX   = (1 << (PEND_W - 1)) - 1;
  localparam int LMAX   = (1 << WIDTH) - 1;

  logic                     clk_i = 1'b0;
  logic                     reset_i = 1'b0;
  logic [WIDTH-1:0]         div_i = '0;
  logic                     positiveShift_i = 1'b0;
  logic                     negativeShift_i = 1'b0;
  logic                     ovf_clr_i = 1'b0;
  logic                     out_o;
  logic                     period_o;
  logic signed [PEND_W-1:0] pending_o;
  logic                     ovf_o;
`ifdef PHASE_SHIFT_DIVIDER_STATS_EN
  logic [15:0]              adv_cnt;
  logic [15:0]              ret_cnt;
`endif

  phase_shift_divider #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .PEND_W(PEND_W)
  ) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .div_i          (div_i),
    .positiveShift_i(positiveShift_i),
    .negativeShift_i(negativeShift_i),
    .ovf_clr_i      (ovf_clr_i),
    .out_o          (out_o),
    .period_o       (period_o),
    .pending_o      (pending_o),
    .ovf_o          (ovf_o)
`ifdef PHASE_SHIFT_DIVIDER_STATS_EN
    ,
    .adv_cnt_o      (adv_cnt),
    .ret_cnt_o      (ret_cnt)
`endif
  );

  always #2.5 clk_i = ~clk_i;   // 200 MHz

  typedef struct packed {
    logic              out;
    logic              per;
    logic [PEND_W-1:0] pend;
    logic              ovf;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  int         m_pend  = 0;
  bit         m_ovf   = 1'b0;
  bit         m_run   = 1'b0;
  logic [1:0] wave[$];          // {out, period} for the rest of the current period
  int         cur_div = 8;

  task automatic model_reset();
    m_pend = 0;
    m_ovf  = 1'b0;
    m_run  = 1'b0;
    wave.delete();
  endtask

  // One reference clock cycle: expected visible outputs for this cycle,
  // then the effect of this cycle's inputs on the next one.
  task automatic model_cycle(input bit pos, input bit neg, input bit clr, input int div);
    int   n;
    int   len;
    int   applied;
    exp_t e;
    applied = 0;
    if (m_run && wave.size() == 0) begin
      n   = (div < 2) ? 2 : div;
      len = n;
      if (m_pend > 0) begin
        len     = (n - STEP < 2) ? 2 : n - STEP;
        applied = 1;
      end else if (m_pend < 0) begin
        len     = (n + STEP > LMAX) ? LMAX : n + STEP;
        applied = -1;
      end
      for (int i = 0; i < len; i++) begin
        wave.push_back({i < len / 2, i == 0});
      end
    end
    e.out  = m_run ? wave[0][1] : 1'b0;
    e.per  = m_run ? wave[0][0] : 1'b0;
    e.pend = PEND_W'(m_pend);
    e.ovf  = m_ovf;
    exp_q.push_back(e);
    if (m_run) begin
      void'(wave.pop_front());
    end
    m_pend = m_pend + int'(pos) - int'(neg) - applied;
    if (m_pend > PMAX) begin
      m_pend = PMAX;
      m_ovf  = 1'b1;
    end else if (m_pend < -PMAX) begin
      m_pend = -PMAX;
      m_ovf  = 1'b1;
    end else if (clr) begin
      m_ovf = 1'b0;
    end
    m_run = 1'b1;
  endtask

  // Drive this cycle's inputs (called just after a rising edge).
  task automatic apply(input bit pos, input bit neg, input bit clr);
    div_i           = WIDTH'(cur_div);
    positiveShift_i = pos;
    negativeShift_i = neg;
    ovf_clr_i       = clr;
    model_cycle(pos, neg, clr, cur_div);
  endtask

  task automatic step(input bit pos, input bit neg, input bit clr);
    @(posedge clk_i);
    #1;
    apply(pos, neg, clr);
  endtask

  task automatic rstep(input int p_pos, input int p_neg, input int p_clr);
    step($urandom_range(99) < p_pos, $urandom_range(99) < p_neg, $urandom_range(99) < p_clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0);
    end
  endtask

  // Asynchronous reset in the middle of operation
  task automatic do_reset();
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    #1;
    checks++;
    if ({out_o, period_o, pending_o, ovf_o} !== 7'b0) begin
      failures++;
      $display("FAIL async_reset t=%0t got out=%0b per=%0b pend=%0d ovf=%0b want all 0",
               $time, out_o, period_o, pending_o, ovf_o);
    end
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    apply(1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare every cycle that has a pushed expectation
  always @(negedge clk_i) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({out_o, period_o, pending_o, ovf_o} !== e) begin
        failures++;
        $display("FAIL cycle t=%0t out/per/pend/ovf got=%0b/%0b/%0d/%0b want=%0b/%0b/%0d/%0b",
                 $time, out_o, period_o, pending_o, ovf_o,
                 e.out, e.per, $signed(e.pend), e.ovf);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #50;
    checks++;
    if ({out_o, period_o, pending_o, ovf_o} !== 7'b0) begin
      failures++;
      $display("FAIL reset_state got out=%0b per=%0b pend=%0d ovf=%0b want all 0",
               out_o, period_o, pending_o, ovf_o);
    end
    #50;
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    apply(1'b0, 1'b0, 1'b0);

    // Baseline: divide by 8, no shifts
    cur_div = 8;
    idle(40);

    // Single advance mid-period, then single retard, then a cancel
    idle(3);
    step(1'b1, 1'b0, 1'b0);
    idle(30);
    step(1'b0, 1'b1, 1'b0);
    idle(30);
    step(1'b1, 1'b1, 1'b0);
    idle(20);

    // Burst to positive saturation, drain, clear
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
    idle(70);
    step(1'b0, 1'b0, 1'b1);
    idle(10);

    // Burst to negative saturation with clear colliding with a set
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    idle(90);
    step(1'b0, 1'b0, 1'b1);

    // Clamp at the minimum length
    cur_div = 2;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    idle(20);
    cur_div = 1;
    idle(6);
    cur_div = 0;
    step(1'b1, 1'b0, 1'b0);
    idle(10);

    // Clamp at the maximum length
    cur_div = 255;
    step(1'b0, 1'b1, 1'b0);
    idle(600);

    // Divisor change mid-period
    cur_div = 8;
    idle(20);
    cur_div = 12;
    idle(40);

    // Reset while shifts are queued
    cur_div = 5;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    do_reset();
    idle(20);

    // Randomised traffic
    for (int c = 0; c < 400 && failures < 20; c++) begin
      if ($urandom_range(99) < 4) cur_div = $urandom_range(0, 12);
      rstep(60, 5, 3);
    end
    for (int c = 0; c < 3000 && failures < 20; c++) begin
      if ($urandom_range(99) < 3) cur_div = $urandom_range(0, 20);
      if ($urandom_range(999) < 2) cur_div = $urandom_range(240, 255);
      rstep(15, 15, 4);
    end

    @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending expectations want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
